// File: rtl/mem_bist_ctrl.sv
// Write/read-back memory self-test controller: writes NUM_WORDS seeded patterns,
// reads them back in order, counts miscompares and reports pass/fail.
module mem_bist_ctrl #(
   parameter int                NUM_WORDS = 5,
   parameter int                ADDR_W    = 24,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] PATT_SEED = 32'h00FFFFFF,
   parameter int                TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_rdy,
   input  logic              rd_rdy,
   input  logic              rd_data_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [15:0]       err_cnt
);

   localparam int CW = ADDR_W + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
   localparam logic [CW-1:0] ALL_WORDS = CW'(NUM_WORDS);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]     ret_cnt_q, ret_cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [15:0]       err_cnt_q, err_cnt_d;

   logic ret_live, progress, timeout, finish, run_ok;

   function automatic logic [DATA_W-1:0] patt(input logic [ADDR_W-1:0] a);
      return PATT_SEED ^ DATA_W'(a);
   endfunction

   // Request state is registered; the strobe is qualified by the same-cycle ready.
   assign wr_en   = (state_q == S_WRITE) && wr_rdy;
   assign rd_en   = (state_q == S_READ) && rd_rdy;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rd_addr = rd_addr_q;
   assign busy    = busy_q;
   assign pass    = pass_q;
   assign fail    = fail_q;
   assign err_cnt = err_cnt_q;

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      ret_cnt_d = ret_cnt_q;
      timer_d   = timer_q;
      ovf_d     = ovf_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      busy_d    = busy_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_cnt_d = err_cnt_q;
      timeout   = 1'b0;
      finish    = 1'b0;
      run_ok    = 1'b0;

      // Returns are only meaningful once a run has been started.
      ret_live = rd_data_valid && (state_q != S_IDLE);
      progress = wr_en || rd_en || ret_live;

      if (ret_live) begin
         if (ret_cnt_q != rd_cnt_q) begin
            ret_cnt_d = ret_cnt_q + 1'b1;
            if (rd_data != patt(ret_cnt_q[ADDR_W-1:0]) && err_cnt_q != 16'hFFFF) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         S_WRITE: begin
            if (wr_en) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LAST_WORD) begin
                  state_d = S_READ;
               end else begin
                  wr_addr_d = wr_cnt_d[ADDR_W-1:0];
                  wr_data_d = patt(wr_cnt_d[ADDR_W-1:0]);
               end
            end
         end
         S_READ: begin
            if (rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LAST_WORD) begin
                  state_d = S_DRAIN;
               end else begin
                  rd_addr_d = rd_cnt_d[ADDR_W-1:0];
               end
            end
         end
         S_DRAIN: begin
            if (ret_cnt_q == ALL_WORDS) begin
               finish = 1'b1;
            end
         end
         S_DONE: begin
            // A stray return after completion still condemns the run.
            if (ovf_d) begin
               pass_d = 1'b0;
               fail_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN) begin
         if (progress) begin
            timer_d = '0;
         end else if (timer_q == TMO_LIMIT) begin
            timeout = 1'b1;
            finish  = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      if (finish) begin
         run_ok  = (err_cnt_d == 16'd0) && !ovf_d && !timeout;
         state_d = S_DONE;
         busy_d  = 1'b0;
         pass_d  = run_ok;
         fail_d  = !run_ok;
      end

      if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d   = S_WRITE;
         wr_cnt_d  = '0;
         rd_cnt_d  = '0;
         ret_cnt_d = '0;
         timer_d   = '0;
         ovf_d     = 1'b0;
         wr_addr_d = '0;
         wr_data_d = patt('0);
         rd_addr_d = '0;
         busy_d    = 1'b1;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         ret_cnt_q <= '0;
         timer_q   <= '0;
         ovf_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         ret_cnt_q <= ret_cnt_d;
         timer_q   <= timer_d;
         ovf_q     <= ovf_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: a 3-cycle-latency memory model with fault
// injection, expected strobes/results queued by the stimulus, checked by a monitor.
module tb_mem_bist_ctrl;

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic [15:0] err;
      logic        chk_cnt;
      logic [7:0]  nwr;
      logic [7:0]  nrd;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        wr_rdy = 1'b1;
   logic        rd_rdy = 1'b1;
   logic        rd_data_valid = 1'b0;
   logic [31:0] rd_data = '0;
   logic        wr_en, rd_en, busy, pass, fail;
   logic [23:0] wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [15:0] err_cnt;

   mem_bist_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .wr_rdy(wr_rdy), .rd_rdy(rd_rdy),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .busy(busy), .pass(pass), .fail(fail), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Hand-computed pattern for addresses 0..4 with seed 32'h00FFFFFF.
   logic [31:0] exp_data [5] = '{32'h00FFFFFF, 32'h00FFFFFE, 32'h00FFFFFD,
                                 32'h00FFFFFC, 32'h00FFFFFB};

   logic [55:0] exp_wr_q [$];
   logic [23:0] exp_rd_q [$];
   res_t        exp_res_q [$];

   // Test mode flags, written only by the stimulus process.
   bit rand_rdy, corrupt2, drop_last, inj_after, inj_wr;
   int rst_chk_req = 0;

   // Monitor-owned state.
   int checks = 0;
   int failures = 0;
   int res_cnt = 0;
   int wr_seen = 0;
   int rd_seen = 0;
   int rst_chk_done = 0;
   logic busy_prev = 1'b0;

   int cyc = 0;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      wr_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Memory model: acts on the strobes seen mid-cycle, returns data 3 edges later.
   logic [31:0] mem [16];
   int          due_q [$];
   logic [3:0]  raddr_q [$];
   int          ret_n = 0;
   bit          inject_next = 0;
   bit          injected = 0;
   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   always @(negedge clk) begin
      logic [3:0] a;
      if (start) begin
         ret_n = 0;
         injected = 0;
         inject_next = 0;
      end
      if (wr_en === 1'b1) mem[wr_addr[3:0]] = wr_data;
      rd_data_valid = 1'b0;
      rd_data = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         void'(due_q.pop_front());
         a = raddr_q.pop_front();
         ret_n++;
         if (!(drop_last && ret_n == 5)) begin
            rd_data_valid = 1'b1;
            rd_data = mem[a] ^ ((corrupt2 && a == 4'd2) ? 32'd1 : 32'd0);
            if (inj_after && ret_n == 5) inject_next = 1;
         end
      end else if (inject_next) begin
         rd_data_valid = 1'b1;
         rd_data = 32'h00FFFFFF;
         inject_next = 0;
      end
      if (inj_wr && !injected && wr_en === 1'b1) begin
         rd_data_valid = 1'b1;
         rd_data = 32'h00FFFFFF;
         injected = 1;
      end
      if (rd_en === 1'b1) begin
         due_q.push_back(cyc + 3);
         raddr_q.push_back(rd_addr[3:0]);
      end
   end

   always @(negedge clk) begin
      logic [100:0] act_rst;
      logic [55:0]  ew;
      logic [23:0]  er;
      res_t         got, need;
      if (rst_chk_req != rst_chk_done) begin
         rst_chk_done = rst_chk_req;
         act_rst = {wr_en, rd_en, busy, pass, fail, err_cnt, wr_addr, rd_addr, wr_data};
         checks++;
         if (act_rst !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0", act_rst);
         end
         $display("RST outputs=%h", act_rst);
      end
      if (wr_en === 1'b1) begin
         checks++;
         if (wr_rdy !== 1'b1) begin
            failures++;
            $display("FAIL wr_en_without_rdy got wr_rdy=%b required=1", wr_rdy);
         end
         checks++;
         if (exp_wr_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got addr=%h data=%h required=none", wr_addr, wr_data);
         end else begin
            ew = exp_wr_q.pop_front();
            if ({wr_addr, wr_data} !== ew) begin
               failures++;
               $display("FAIL wr_txn got addr=%h data=%h required addr=%h data=%h",
                        wr_addr, wr_data, ew[55:32], ew[31:0]);
            end
         end
         $display("WR addr=%h data=%h", wr_addr, wr_data);
         wr_seen++;
      end
      if (rd_en === 1'b1) begin
         checks++;
         if (rd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rd_en_without_rdy got rd_rdy=%b required=1", rd_rdy);
         end
         checks++;
         if (exp_rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got addr=%h required=none", rd_addr);
         end else begin
            er = exp_rd_q.pop_front();
            if (rd_addr !== er) begin
               failures++;
               $display("FAIL rd_txn got addr=%h required addr=%h", rd_addr, er);
            end
         end
         $display("RD addr=%h", rd_addr);
         rd_seen++;
      end
      if (busy_prev && busy === 1'b0) begin
         checks++;
         if (exp_res_q.size() == 0) begin
            failures++;
            $display("FAIL run_end_unexpected got pass=%b fail=%b err=%0d required=none",
                     pass, fail, err_cnt);
         end else begin
            need = exp_res_q.pop_front();
            got = '{pass: pass, fail: fail, err: err_cnt, chk_cnt: need.chk_cnt,
                    nwr: need.chk_cnt ? 8'(wr_seen) : 8'd0,
                    nrd: need.chk_cnt ? 8'(rd_seen) : 8'd0};
            if (!need.chk_cnt) begin
               need.nwr = 8'd0;
               need.nrd = 8'd0;
            end
            if (got !== need) begin
               failures++;
               $display("FAIL run_result got pass=%b fail=%b err=%0d wr=%0d rd=%0d required pass=%b fail=%b err=%0d wr=%0d rd=%0d",
                        got.pass, got.fail, got.err, got.nwr, got.nrd,
                        need.pass, need.fail, need.err, need.nwr, need.nrd);
            end
         end
         $display("RUN pass=%b fail=%b err=%0d writes=%0d reads=%0d", pass, fail, err_cnt, wr_seen, rd_seen);
         wr_seen = 0;
         rd_seen = 0;
         res_cnt++;
      end
      busy_prev = (busy === 1'b1);
   end

   task automatic queue_run(input logic p, input logic f, input logic [15:0] e, input logic chk);
      res_t r;
      for (int i = 0; i < 5; i++) begin
         exp_wr_q.push_back({24'(i), exp_data[i]});
         exp_rd_q.push_back(24'(i));
      end
      r = '{pass: p, fail: f, err: e, chk_cnt: chk, nwr: 8'd5, nrd: 8'd5};
      exp_res_q.push_back(r);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_case(input bit c2, input bit rr, input bit dl, input bit ia, input bit iw,
                           input logic p, input logic f, input logic [15:0] e);
      int r0;
      corrupt2 = c2; rand_rdy = rr; drop_last = dl; inj_after = ia; inj_wr = iw;
      queue_run(p, f, e, 1'b1);
      r0 = res_cnt;
      pulse_start();
      for (int i = 0; i < 3000 && res_cnt == r0; i++) @(posedge clk);
      if (res_cnt == r0) begin
         $display("FAIL run_timeout got busy=%b required=0 within 3000 cycles", busy);
         $fatal(1, "run did not complete");
      end
      corrupt2 = 0; rand_rdy = 0; drop_last = 0; inj_after = 0; inj_wr = 0;
      repeat (8) @(posedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rst_chk_req++;
      repeat (3) @(posedge clk);

      run_case(0, 0, 0, 0, 0, 1'b1, 1'b0, 16'd0);   // clean run
      run_case(1, 0, 0, 0, 0, 1'b0, 1'b1, 16'd1);   // word 2 corrupted
      run_case(0, 1, 0, 0, 0, 1'b1, 1'b0, 16'd0);   // random ready
      run_case(0, 0, 1, 0, 0, 1'b0, 1'b1, 16'd0);   // last return dropped
      run_case(0, 0, 0, 1, 0, 1'b0, 1'b1, 16'd0);   // extra return after the last
      run_case(0, 0, 0, 0, 1, 1'b0, 1'b1, 16'd0);   // extra return during writes

      // Abort during READ, then a normal run.
      queue_run(1'b0, 1'b0, 16'd0, 1'b0);
      pulse_start();
      for (int i = 0; i < 200 && rd_seen < 2; i++) @(posedge clk);
      if (rd_seen < 2) begin
         $display("FAIL read_phase_timeout got reads=%0d required=2", rd_seen);
         $fatal(1, "read phase not reached");
      end
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_wr_q.delete();
      exp_rd_q.delete();
      rst_chk_req++;
      repeat (10) @(posedge clk);
      run_case(0, 0, 0, 0, 0, 1'b1, 1'b0, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
